// File: rtl/offchip_mem_channel_model.sv
// offchip_mem_channel_model: N-channel external memory model with per-channel latency FSMs,
// a preload port and sticky protocol/range error flags.
module offchip_mem_channel_model #(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int DEPTH     = 32,
  parameter int BASE_ADDR = 0,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          Mout_oe_ram,
  input  logic [N_CH-1:0]          Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  input  logic                     init_we,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic [DATA_W-1:0]        init_data,
  output logic                     proto_err,
  output logic                     range_err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LAT_MAX = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW = $clog2(LAT_MAX + 1);
  localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] HI = (ADDR_W+1)'(BASE_ADDR + DEPTH);
  localparam logic [CW-1:0] RD_END = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_END = CW'(WRITE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] s);
    for (int b = 0; b < DATA_W; b++) size_mask[b] = b < int'(s);
  endfunction

  logic [DATA_W-1:0]             mem [DEPTH];
  logic [N_CH-1:0]               in_win, wr_commit;
  logic [N_CH-1:0][IW-1:0]       idx;
  logic [N_CH-1:0][DATA_W-1:0]   wmask;
  logic                          proto_q, range_q;
  logic                          init_ok;

  assign init_ok = {1'b0, init_addr} < (ADDR_W+1)'(DEPTH);
  assign proto_err = proto_q;
  assign range_err = range_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic              oe, we, rd_ok, wr_ok, rd_done, wr_done, rdy;
    logic [ADDR_W:0]   a;
    logic [DATA_W-1:0] rdata_q, rdata;
    logic [CW-1:0]     cnt_q, cnt_d;
    state_e            state_q, state_d;
    assign oe = Mout_oe_ram[k];
    assign we = Mout_we_ram[k];
    assign a = {1'b0, Mout_addr_ram[k*ADDR_W +: ADDR_W]};
    assign in_win[k] = a >= LO && a < HI;
    assign idx[k] = in_win[k] ? IW'(a - LO) : '0;
    assign wmask[k] = size_mask(Mout_data_ram_size[k*SIZE_W +: SIZE_W]);
    // a request switching kind mid-flight restarts from IDLE
    assign rd_ok = oe && !we && in_win[k] && state_q != WR;
    assign wr_ok = we && !oe && in_win[k] && state_q != RD;
    assign rd_done = rd_ok && cnt_q == RD_END;
    assign wr_done = wr_ok && cnt_q == WR_END;
    assign wr_commit[k] = wr_done;
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    always_comb begin
      state_d = (rd_ok && !rd_done) ? RD : (wr_ok && !wr_done) ? WR : IDLE;
      cnt_d   = state_d == IDLE ? '0 : cnt_q + 1'b1;
    end
    always_comb begin
      rdy   = rd_done || wr_done;
      rdata = rd_done ? rdata_q & wmask[k] : '0;
    end
    always_ff @(posedge clock or negedge reset)
      if (!reset) rdata_q <= '0;
      else        rdata_q <= mem[idx[k]];
    assign M_DataRdy[k] = rdy;
    assign M_Rdata_ram[k*DATA_W +: DATA_W] = rdata;
  end

  // ascending channel order then preload: the last assignment wins on a shared word
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++)
      if (reset && wr_commit[i])
        mem[idx[i]] <= (Mout_Wdata_ram[i*DATA_W +: DATA_W] & wmask[i]) | (mem[idx[i]] & ~wmask[i]);
    if (init_we && init_ok) mem[init_addr[IW-1:0]] <= init_data;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      proto_q <= 1'b0;
      range_q <= 1'b0;
    end else begin
      proto_q <= proto_q | (|(Mout_oe_ram & Mout_we_ram));
      range_q <= range_q | (|((Mout_oe_ram | Mout_we_ram) & ~in_win));
    end
endmodule

// File: tb/tb_offchip_mem_channel_model.sv
// tb_offchip_mem_channel_model: directed checks on two small configurations plus randomized
// 4-channel 32-bit traffic compared against a word-array reference model.
module tb_offchip_mem_channel_model;
  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [1:0]   oe0, we0, rdy0;
  logic [13:0]  addr0;
  logic [15:0]  wd0, rd0;
  logic [7:0]   sz0, idata0;
  logic [6:0]   iaddr0;
  logic         iwe0, pe0, re0;

  logic [1:0]   oe1, we1, rdy1;
  logic [13:0]  addr1;
  logic [15:0]  wd1, rd1;
  logic [7:0]   sz1, idata1;
  logic [6:0]   iaddr1;
  logic         iwe1, pe1, re1;

  logic [3:0]   oe2, we2, rdy2;
  logic [27:0]  addr2;
  logic [127:0] wd2, rd2;
  logic [23:0]  sz2;
  logic [31:0]  idata2;
  logic [6:0]   iaddr2;
  logic         iwe2, pe2, re2;

  offchip_mem_channel_model dut0 (
    .clock(clock), .reset(rst_n), .Mout_oe_ram(oe0), .Mout_we_ram(we0), .Mout_addr_ram(addr0),
    .Mout_Wdata_ram(wd0), .Mout_data_ram_size(sz0), .M_Rdata_ram(rd0), .M_DataRdy(rdy0),
    .init_we(iwe0), .init_addr(iaddr0), .init_data(idata0), .proto_err(pe0), .range_err(re0));

  offchip_mem_channel_model #(.READ_LAT(4), .WRITE_LAT(3)) dut1 (
    .clock(clock), .reset(rst_n), .Mout_oe_ram(oe1), .Mout_we_ram(we1), .Mout_addr_ram(addr1),
    .Mout_Wdata_ram(wd1), .Mout_data_ram_size(sz1), .M_Rdata_ram(rd1), .M_DataRdy(rdy1),
    .init_we(iwe1), .init_addr(iaddr1), .init_data(idata1), .proto_err(pe1), .range_err(re1));

  offchip_mem_channel_model #(.N_CH(4), .DATA_W(32), .SIZE_W(6), .BASE_ADDR(8), .READ_LAT(5)) dut2 (
    .clock(clock), .reset(rst_n), .Mout_oe_ram(oe2), .Mout_we_ram(we2), .Mout_addr_ram(addr2),
    .Mout_Wdata_ram(wd2), .Mout_data_ram_size(sz2), .M_Rdata_ram(rd2), .M_DataRdy(rdy2),
    .init_we(iwe2), .init_addr(iaddr2), .init_data(idata2), .proto_err(pe2), .range_err(re2));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clock);
  endtask

  task automatic ed();
    @(posedge clock);
    #1;
  endtask

  task automatic preload0(input logic [6:0] a, input logic [7:0] d);
    iwe0 = 1'b1; iaddr0 = a; idata0 = d;
    ed();
    iwe0 = 1'b0;
  endtask

  // two-cycle read on dut0: nothing in cycle 1, strobe and data in cycle 2
  task automatic read0(input string tag, input int ch, input logic [6:0] a, input logic [3:0] s,
                       input logic [7:0] exp);
    oe0 = 2'(1 << ch);
    addr0[ch*7 +: 7] = a;
    sz0[ch*4 +: 4] = s;
    nx();
    chk({tag, "_c1_rdy"}, 128'(rdy0), 128'(0));
    ed();
    nx();
    chk({tag, "_c2_rdy"}, 128'(rdy0), 128'(1 << ch));
    chk({tag, "_c2_data"}, 128'(rd0), 128'(exp) << (8*ch));
    ed();
    oe0 = 2'b00;
  endtask

  function automatic logic [31:0] bmask(input int s);
    return s >= 32 ? 32'hFFFF_FFFF : (32'd1 << s) - 32'd1;
  endfunction

  logic [31:0] m2 [32];
  int          op [4];
  int          a2 [4];
  int          s2 [4];
  logic [31:0] d2 [4];

  initial begin
    rst_n = 1'b0;
    {oe0, we0, addr0, wd0, sz0, iwe0, iaddr0, idata0} = '0;
    {oe1, we1, addr1, wd1, sz1, iwe1, iaddr1, idata1} = '0;
    {oe2, we2, addr2, wd2, sz2, iwe2, iaddr2, idata2} = '0;
    nx();
    chk("reset_rdy0", 128'(rdy0), 128'(0));
    chk("reset_rdata0", 128'(rd0), 128'(0));
    chk("reset_errs0", 128'({pe0, re0}), 128'(0));
    chk("reset_rdy2", 128'(rdy2), 128'(0));
    chk("reset_rdata2", rd2, 128'(0));
    ed();
    rst_n = 1'b1;

    preload0(7'd3, 8'hA5);
    read0("t1_read", 0, 7'd3, 4'd8, 8'hA5);
    read0("size4_read", 0, 7'd3, 4'd4, 8'h05);
    read0("size0_read", 0, 7'd3, 4'd0, 8'h00);

    preload0(7'd7, 8'hF0);
    we0 = 2'b10; addr0[13:7] = 7'd7; wd0[15:8] = 8'h3C; sz0[7:4] = 4'd4;
    nx();
    chk("t2_write_rdy", 128'(rdy0), 128'(2'b10));
    ed();
    we0 = 2'b00;
    read0("t2_readback", 1, 7'd7, 4'd8, 8'hFC);

    we0 = 2'b11; addr0 = {7'd5, 7'd5}; wd0 = {8'h22, 8'h11}; sz0 = {4'd8, 4'd8};
    nx();
    chk("t3_both_rdy", 128'(rdy0), 128'(2'b11));
    ed();
    we0 = 2'b00;
    read0("t3_high_wins", 0, 7'd5, 4'd8, 8'h22);
    we0 = 2'b11; addr0 = {7'd5, 7'd5}; wd0 = {8'h44, 8'h55}; sz0 = {4'd8, 4'd8};
    iwe0 = 1'b1; iaddr0 = 7'd5; idata0 = 8'h33;
    ed();
    we0 = 2'b00; iwe0 = 1'b0;
    read0("t3_init_wins", 1, 7'd5, 4'd8, 8'h33);

    nx();
    chk("t4_errs_clear", 128'({pe0, re0}), 128'(0));
    ed();
    oe0 = 2'b01; addr0[6:0] = 7'd32; sz0[3:0] = 4'd8;
    for (int i = 0; i < 10; i++) begin
      nx();
      chk("t4_oow_rdy", 128'(rdy0[0]), 128'(0));
      chk("t4_oow_data", 128'(rd0[7:0]), 128'(0));
      ed();
    end
    oe0 = 2'b00;
    nx();
    chk("t4_range_err", 128'(re0), 128'(1));
    chk("t4_proto_quiet", 128'(pe0), 128'(0));
    ed();
    oe0 = 2'b10; we0 = 2'b10; addr0[13:7] = 7'd1; sz0[7:4] = 4'd8;
    nx();
    chk("t4_both_rdy", 128'(rdy0), 128'(0));
    ed();
    oe0 = 2'b00; we0 = 2'b00;
    nx();
    chk("t4_proto_err", 128'(pe0), 128'(1));
    ed();
    nx();
    chk("t4_proto_sticky", 128'(pe0), 128'(1));
    chk("t4_range_sticky", 128'(re1 | re0), 128'(1));
    ed();

    iwe1 = 1'b1; iaddr1 = 7'd9; idata1 = 8'h5A;
    ed();
    iwe1 = 1'b0;
    oe1 = 2'b01; addr1[6:0] = 7'd9; sz1[3:0] = 4'd8;
    nx();
    chk("t5_drop_c1", 128'(rdy1), 128'(0));
    ed();
    oe1 = 2'b00;
    for (int i = 0; i < 5; i++) begin
      nx();
      chk("t5_drop_idle", 128'(rdy1), 128'(0));
      ed();
    end
    oe1 = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      nx();
      chk("t5_read_rdy", 128'(rdy1), 128'(c == 4 ? 1 : 0));
      if (c == 4) chk("t5_read_data", 128'(rd1), 128'(16'h005A));
      ed();
    end
    oe1 = 2'b00;
    we1 = 2'b01; wd1[7:0] = 8'hC3;
    for (int c = 1; c <= 2; c++) begin
      nx();
      chk("t5_write_wait", 128'(rdy1), 128'(0));
      ed();
    end
    nx();
    chk("t5_write_rdy_c3", 128'(rdy1), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_reset_kills_rdy", 128'(rdy1), 128'(0));
    we1 = 2'b00;
    ed();
    rst_n = 1'b1;
    nx();
    chk("t5_reset_clears_errs", 128'({pe0, re0}), 128'(0));
    ed();
    oe1 = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      nx();
      chk("t5_kept_rdy", 128'(rdy1), 128'(c == 4 ? 1 : 0));
      if (c == 4) chk("t5_word_unchanged", 128'(rd1), 128'(16'h005A));
      ed();
    end
    oe1 = 2'b00;
    addr1[6:0] = 7'd10; we1 = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      nx();
      chk("t5_full_write_rdy", 128'(rdy1), 128'(c == 3 ? 1 : 0));
      ed();
    end
    we1 = 2'b00; oe1 = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      nx();
      if (c == 4) chk("t5_full_write_data", 128'(rd1), 128'(16'h00C3));
      ed();
    end
    oe1 = 2'b00;

    for (int i = 0; i < 32; i++) begin
      iwe2 = 1'b1; iaddr2 = 7'(i); idata2 = $urandom;
      m2[i] = idata2;
      ed();
    end
    iwe2 = 1'b0;
    for (int r = 0; r < 60; r++) begin
      for (int ch = 0; ch < 4; ch++) begin
        op[ch] = $urandom_range(0, 2);
        a2[ch] = $urandom_range(0, 31);
        s2[ch] = $urandom_range(0, 40);
        d2[ch] = $urandom;
        oe2[ch] = op[ch] == 1;
        we2[ch] = op[ch] == 2;
        addr2[ch*7 +: 7] = 7'(a2[ch] + 8);
        wd2[ch*32 +: 32] = d2[ch];
        sz2[ch*6 +: 6] = 6'(s2[ch]);
      end
      for (int c = 1; c <= 5; c++) begin
        nx();
        for (int ch = 0; ch < 4; ch++) begin
          chk("t6_rdy", 128'(rdy2[ch]), 128'((op[ch] == 1 && c == 5) || (op[ch] == 2 && c == 1)));
          if (op[ch] == 1 && c == 5)
            chk("t6_rdata", 128'(rd2[ch*32 +: 32]), 128'(m2[a2[ch]] & bmask(s2[ch])));
        end
        ed();
        if (c == 1) begin
          for (int ch = 0; ch < 4; ch++)
            if (op[ch] == 2) m2[a2[ch]] = (d2[ch] & bmask(s2[ch])) | (m2[a2[ch]] & ~bmask(s2[ch]));
          we2 = 4'b0000;
        end
      end
    end
    oe2 = 4'b0000;
    nx();
    chk("t6_no_errs", 128'({pe2, re2}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
